// File: rtl/piezo_pkg.sv
// piezo_pkg: shared types and the stored tone patterns for piezo_pattern_gen.
//   step_t  : one pattern step {half, cnt, rest, last}
//   rom_t   : NUM_PAT x STEPS table of steps
//   state_t : controller FSM states
//   PAT_*   : pattern indices used by the calculator control FSM
package piezo_pkg;

    localparam int P_HALF_W  = 18;
    localparam int P_CNT_W   = 8;
    localparam int P_NUM_PAT = 4;
    localparam int P_STEPS   = 4;

    localparam int PAT_ERR    = 0;
    localparam int PAT_ACK    = 1;
    localparam int PAT_RESULT = 2;
    localparam int PAT_TEST   = 3;

    // half: half-period in USER_CLK cycles (values below 2 act as 2)
    // cnt : number of half-period units in the step (0 = skip step)
    // rest: keep the speaker low for the step's duration
    // last: final step of the pattern
    typedef struct packed {
        logic [P_HALF_W-1:0] half;
        logic [P_CNT_W-1:0]  cnt;
        logic                rest;
        logic                last;
    } step_t;

    typedef step_t [P_NUM_PAT-1:0][P_STEPS-1:0] rom_t;

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_DONE} state_t;

    function automatic step_t mk_step(int half, int cnt, bit rest, bit last);
        step_t s;
        s.half = P_HALF_W'(half);
        s.cnt  = P_CNT_W'(cnt);
        s.rest = rest;
        s.last = last;
        return s;
    endfunction

    function automatic rom_t build_rom();
        rom_t r;
        r = '0;
        // Legacy error beep: same pitch and length as the old single-note buzzer.
        r[PAT_ERR][0]    = mk_step(213636, 60, 1'b0, 1'b1);
        // Short rising chirp on key accept.
        r[PAT_ACK][0]    = mk_step(25000, 40, 1'b0, 1'b0);
        r[PAT_ACK][1]    = mk_step(18750, 54, 1'b0, 1'b1);
        // Result-ready: note, short gap, higher note.
        r[PAT_RESULT][0] = mk_step(28409, 44, 1'b0, 1'b0);
        r[PAT_RESULT][1] = mk_step(10000, 10, 1'b1, 1'b0);
        r[PAT_RESULT][2] = mk_step(21276, 94, 1'b0, 1'b1);
        // Short pattern for bring-up and simulation.
        r[PAT_TEST][0]   = mk_step(4, 4, 1'b0, 1'b0);
        r[PAT_TEST][1]   = mk_step(3, 2, 1'b1, 1'b0);
        r[PAT_TEST][2]   = mk_step(2, 2, 1'b0, 1'b1);
        return r;
    endfunction

    localparam rom_t PAT_ROM = build_rom();

endpackage

// File: rtl/piezo_pattern_gen_if.sv
// piezo_pattern_gen_if: control handshake between the calculator FSM and the
// pattern generator.
//   start   : one-cycle play request (master -> slave)
//   pat_sel : pattern index, valid with start (master -> slave)
//   abort   : stop playback immediately (master -> slave)
//   busy    : pattern playing (slave -> master)
//   done    : one-cycle pulse on normal completion (slave -> master)
interface piezo_pattern_gen_if #(
    parameter int PW = 2
) ();
    logic          start;
    logic [PW-1:0] pat_sel;
    logic          abort;
    logic          busy;
    logic          done;

    modport master (output start, pat_sel, abort, input busy, done);
    modport slave  (input start, pat_sel, abort, output busy, done);
endinterface

// File: rtl/piezo_step_timer.sv
// piezo_step_timer: per-step timing for the pattern generator.
//   USER_CLK, USER_RST : clock, synchronous active-high reset
//   en       : step is running; low clears both counters
//   half,cnt : current step's half-period and unit count
//   tick     : last cycle of a half-period
//   step_end : last cycle of the step (also the single cycle of a cnt==0 step)
module piezo_step_timer #(
    parameter int HALF_W = 18,
    parameter int CNT_W  = 8
) (
    input  logic              USER_CLK,
    input  logic              USER_RST,
    input  logic              en,
    input  logic [HALF_W-1:0] half,
    input  logic [CNT_W-1:0]  cnt,
    output logic              tick,
    output logic              step_end
);
    logic [HALF_W-1:0] ctr;
    logic [HALF_W-1:0] heff;
    logic [CNT_W-1:0]  tcnt;

    // A half-period of 0 or 1 would give no usable square wave; clamp to 2.
    assign heff     = (half < HALF_W'(2)) ? HALF_W'(2) : half;
    assign tick     = en && (ctr == heff - HALF_W'(1));
    // Terminal compares fire before either counter can wrap.
    assign step_end = en && ((cnt == '0) || (tick && (tcnt + CNT_W'(1) == cnt)));

    always_ff @(posedge USER_CLK) begin
        if (USER_RST || !en || step_end) begin
            ctr  <= '0;
            tcnt <= '0;
        end else if (tick) begin
            ctr  <= '0;
            tcnt <= tcnt + CNT_W'(1);
        end else begin
            ctr  <= ctr + HALF_W'(1);
        end
    end
endmodule

// File: rtl/piezo_pattern_gen.sv
// piezo_pattern_gen: plays one of NUM_PAT stored tone/rest patterns on the piezo.
//   USER_CLK, USER_RST : clock, synchronous active-high reset
//   ctl                : start/pat_sel/abort in, busy/done out
//   PIEZO_SPEAKER      : square-wave drive to the board piezo
module piezo_pattern_gen
    import piezo_pkg::*;
#(
    parameter int HALF_W  = P_HALF_W,
    parameter int CNT_W   = P_CNT_W,
    parameter int NUM_PAT = P_NUM_PAT,
    parameter int STEPS   = P_STEPS,
    parameter step_t [NUM_PAT-1:0][STEPS-1:0] ROM = PAT_ROM
) (
    input  logic                USER_CLK,
    input  logic                USER_RST,
    piezo_pattern_gen_if.slave  ctl,
    output logic                PIEZO_SPEAKER
);
    localparam int PW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_t        state, nxt;
    logic [PW-1:0] pat;
    logic [SW-1:0] step_idx;
    step_t         cur;
    logic          tick, step_end, last_step, run;

    assign cur       = ROM[pat][step_idx];
    assign last_step = cur.last || (step_idx == SW'(STEPS - 1));
    // Gating with abort keeps a same-cycle tick from touching the speaker.
    assign run       = (state == ST_PLAY) && !ctl.abort;

    piezo_step_timer #(.HALF_W(HALF_W), .CNT_W(CNT_W)) u_timer (
        .USER_CLK (USER_CLK),
        .USER_RST (USER_RST),
        .en       (run),
        .half     (cur.half),
        .cnt      (cur.cnt),
        .tick     (tick),
        .step_end (step_end)
    );

    always_ff @(posedge USER_CLK) begin
        if (USER_RST) state <= ST_IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (ctl.abort) begin
            nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (ctl.start) nxt = ST_PLAY;
                ST_PLAY: if (step_end && last_step) nxt = ST_DONE;
                default: nxt = ST_IDLE;
            endcase
        end
    end

    // busy/done decode straight from the state register, so a DONE cycle
    // already in flight still shows its pulse even if abort arrives.
    assign ctl.busy = (state == ST_PLAY);
    assign ctl.done = (state == ST_DONE);

    always_ff @(posedge USER_CLK) begin
        if (USER_RST) begin
            pat           <= '0;
            step_idx      <= '0;
            PIEZO_SPEAKER <= 1'b0;
        end else if (ctl.abort) begin
            step_idx      <= '0;
            PIEZO_SPEAKER <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctl.start) begin
                        // Out-of-range selections fall back to the error beep.
                        pat           <= (int'(ctl.pat_sel) >= NUM_PAT) ? '0 : ctl.pat_sel;
                        step_idx      <= '0;
                        PIEZO_SPEAKER <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (step_end) begin
                        // Every step starts from a low speaker, whatever the toggle parity.
                        PIEZO_SPEAKER <= 1'b0;
                        if (!last_step) step_idx <= step_idx + SW'(1);
                    end else if (tick) begin
                        PIEZO_SPEAKER <= cur.rest ? 1'b0 : ~PIEZO_SPEAKER;
                    end
                end
                default: step_idx <= '0;
            endcase
        end
    end
endmodule
